pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline.
- Keeps a scoreboard of in-flight destination registers, one entry per stage from E up to and including W.
- Generates fetch/decode stalls, bubble insertion, redirect/interrupt flushes and per-read-port forwarding selects.
- Successor to the fixed E/M/W stage buffers: depth, read-port count and load latency are parameters; stall and flush are new behaviour.

Parameters:
- REG_AW, 5, register address width.
- NUM_RD_PORTS, 2, decode-stage source ports checked.
- PIPE_DEPTH, 3, scoreboard entries (E..W), minimum 2.
- LOAD_READY, 2, entry index (0 = E) at which load data becomes forwardable.
- FWD_W, $clog2(PIPE_DEPTH+1), forwarding select width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- d_valid  in  1  decode stage holds a real instruction.
- d_rs  in  NUM_RD_PORTS*REG_AW  decode source registers.
- d_rs_used  in  NUM_RD_PORTS  source port actually read.
- d_rd  in  REG_AW  decode destination register.
- d_rf_en  in  1  decode instruction writes the register file.
- d_is_load  in  1  decode instruction is a load.
- redirect  in  1  branch taken or jump resolved in E.
- intr  in  1  interrupt/mret redirect.
- stall_f  out  1  hold the PC.
- stall_d  out  1  hold the F/D buffer.
- flush_d  out  1  clear the F/D buffer to a NOP.
- bubble_e  out  1  load a NOP into the D/E buffer.
- fwd_sel  out  NUM_RD_PORTS*FWD_W  0 = register file, k = entry k-1.
- stage_valid  out  PIPE_DEPTH  scoreboard valid bits.
- stall_cycles  out  32  present only with the optional feature.
- flush_events  out  32  present only with the optional feature.

Behaviour:
- Scoreboard entry fields: valid, rd, rf_en, is_load. Reset (rst=0, asynchronous): all fields 0.
- Every clock the scoreboard shifts one entry (entry i moves to i+1, entry PIPE_DEPTH-1 retires). No back-pressure beyond the decode stall.
- Entry 0 load:
  - from decode when d_valid & ~hazard & ~redirect & ~intr;
  - otherwise a bubble (valid=0).
- A match on port p against entry k requires all of: valid, rf_en, rd == rs_p, rd != 0, d_rs_used[p].
- fwd_sel[p] is combinational and equals 1 + (lowest matching k), i.e. the youngest producer; 0 if there is no match.
- Hazard (combinational): some port's youngest match is a load at index k < LOAD_READY.
- On hazard:
  - stall_f = stall_d = bubble_e = 1;
  - fwd_sel is still driven but is don't-care.
- On redirect:
  - flush_d = 1 and bubble_e = 1;
  - entry 0 is cleared on the next edge; older entries are kept, because the branch itself sits in E;
  - stall_f and stall_d are 0, so redirect overrides hazard;
  - the hazard stall is dropped because the dependent instruction is squashed.
- On intr: same outputs as redirect, and additionally all scoreboard entries are invalidated on the next edge. intr has priority over redirect.
- Idle outputs: all outputs 0 while rst is asserted and when no event is present.
- Register x0 never matches and never stalls.
- LOAD_READY = 0 means there are never load-use stalls.
- Latency: outputs are combinational from the current scoreboard and decode inputs; the scoreboard updates one clock later.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles counts cycles with stall_d = 1;
  - flush_events counts cycles with flush_d = 1;
  - both are 32-bit, saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; hazard behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the sb_entry_t struct (valid, rd, rf_en, is_load);
  - constants NOP_INST = 32'h0000_0013 and REG_ZERO = 5'd0.
- One sub-module, hazard_match: a per-port combinational priority matcher returning the youngest matching index and its load flag. It is instantiated NUM_RD_PORTS times.

Test Plan:
- Plain forwarding: "add x5" enters decode, then the next instruction reads x5 on port 0 → fwd_sel[0]=1, no stall. One cycle later a reader of x5 sees fwd_sel=2.
- Load-use: "lw x6" followed by "add x7,x6,x1" (LOAD_READY=2) → stall_f=stall_d=bubble_e=1 for exactly 2 cycles, then fwd_sel[0]=3.
- Redirect during load-use stall: redirect=1 in a hazard cycle → stall_d=0, flush_d=1, bubble_e=1; the next cycle has stage_valid[0]=0.
- Interrupt: scoreboard full (stage_valid=3'b111), pulse intr → next cycle stage_valid=3'b000 and all fwd_sel=0.
- x0 and unused ports: "add x0" then a reader of x0, plus d_rs_used[1]=0 with a matching rs → fwd_sel=0 and no stall.
- Async reset mid-stall: drop rst during a load-use stall → outputs and stage_valid go to 0 immediately, before any clock edge. With HAZARD_PERF_CNT_EN defined, stall_cycles also goes to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the in-order RISC-V core.
// Scoreboard entries carry the destination register of an in-flight instruction.
package pipe_pkg;

    localparam int SB_AW = 5;

    localparam logic [31:0]      NOP_INST = 32'h0000_0013;
    localparam logic [SB_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             rf_en;
        logic             is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-read-port priority matcher against the in-flight scoreboard.
// Returns the youngest (lowest index) matching producer and its load flag.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int IW    = 2
) (
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  logic [AW-1:0]         rs_i,
    input  logic                  used_i,
    output logic                  hit_o,
    output logic [IW-1:0]         idx_o,
    output logic                  load_o
);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used_i && sb_i[k].valid && sb_i[k].rf_en &&
                sb_i[k].rd == SB_AW'(rs_i) &&
                sb_i[k].rd != REG_ZERO) begin
                hit_o  = 1'b1;
                idx_o  = IW'(k);
                load_o = sb_i[k].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller over an E..W destination scoreboard.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3,
    parameter int LOAD_READY   = 2,
    parameter int FWD_W        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           d_valid,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] d_rs,
    input  logic [NUM_RD_PORTS-1:0]        d_rs_used,
    input  logic [REG_AW-1:0]              d_rd,
    input  logic                           d_rf_en,
    input  logic                           d_is_load,
    input  logic                           redirect,
    input  logic                           intr,
    output logic                           stall_f,
    output logic                           stall_d,
    output logic                           flush_d,
    output logic                           bubble_e,
    output logic [NUM_RD_PORTS*FWD_W-1:0]  fwd_sel,
    output logic [PIPE_DEPTH-1:0]          stage_valid
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    flush_events
`endif
);

    sb_entry_t [PIPE_DEPTH-1:0] sb_q, sb_d;

    logic [NUM_RD_PORTS-1:0]            hit;
    logic [NUM_RD_PORTS-1:0]            ld;
    logic [NUM_RD_PORTS-1:0][FWD_W-1:0] idx;

    logic hazard;
    logic flush;
    logic stall;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        hazard_match #(
            .DEPTH (PIPE_DEPTH),
            .AW    (REG_AW),
            .IW    (FWD_W)
        ) u_match (
            .sb_i   (sb_q),
            .rs_i   (d_rs[p*REG_AW +: REG_AW]),
            .used_i (d_rs_used[p]),
            .hit_o  (hit[p]),
            .idx_o  (idx[p]),
            .load_o (ld[p])
        );

        assign fwd_sel[p*FWD_W +: FWD_W] =
            hit[p] ? idx[p] + FWD_W'(1) : '0;
    end

    always_comb begin
        hazard = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (hit[p] && ld[p] && int'(idx[p]) < LOAD_READY) begin
                hazard = 1'b1;
            end
        end
    end

    // A flush squashes the dependent instruction, so it wins over a stall.
    assign flush    = rst & (redirect | intr);
    assign stall    = rst & hazard & ~flush;
    assign stall_f  = stall;
    assign stall_d  = stall;
    assign flush_d  = flush;
    assign bubble_e = stall | flush;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_sv
        assign stage_valid[k] = sb_q[k].valid;
    end

    always_comb begin
        sb_d = '0;
        if (d_valid && !hazard && !redirect && !intr) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].rd      = SB_AW'(d_rd);
            sb_d[0].rf_en   = d_rf_en;
            sb_d[0].is_load = d_is_load;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        if (intr) begin
            sb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule
